uart_frame: RTL and testbench
=============================

Name: uart_frame

Overview:
Parametrised full-duplex UART: the successor to the fixed 8N1 transceiver. Adds configurable data width, optional odd/even parity, 1 or 2 stop bits, and a valid/ready transmit handshake with back-to-back frames. The receiver adds false-start rejection, 3-sample majority voting, and per-frame parity and framing error flags. Sits between a host-side byte/word interface and the board TX/RX pins.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; DIVIDER = CLK_FREQ/BAUD_RATE clocks per bit (integer division); DIVIDER >= 8 is required, and a lower value is an elaboration error
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2; other values are an elaboration error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  payload to send, LSB first on the line
tx_valid  input  1  host offers tx_data
tx_ready  output  1  transmitter accepts tx_data this cycle when tx_valid is also high
tx  output  1  serial line out, idle high
rx  input  1  serial line in, asynchronous to clk
rx_data  output  DATA_BITS  last received payload, held until the next frame
rx_valid  output  1  one-cycle pulse when rx_data and the error flags update
rx_parity_err  output  1  parity mismatch for the frame flagged by rx_valid; always 0 when PARITY = 0
rx_frame_err  output  1  first stop bit sampled low for the frame flagged by rx_valid

Behaviour:
- Reset (async assert, sync deassert is handled externally): tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, both error flags = 0, both FSMs go to IDLE, all counters = 0. Reset mid-frame aborts the frame immediately and tx returns high.
- All outputs are registered. Each bit period is exactly DIVIDER clocks.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready = 1. Acceptance occurs when tx_valid && tx_ready at a rising edge. On acceptance, latch tx_data, set tx_ready = 0, tx = 0 from the next cycle, and enter START.
  - START then DATA: DATA_BITS periods, bit index 0 first.
  - PARITY: present only if PARITY != 0. Odd parity makes the total count of ones (data plus parity) odd; even parity makes it even.
  - STOP: tx = 1 for STOP_BITS periods.
  - On the last clock of the final stop period, tx_ready = 1 for one cycle.
    - If tx_valid is high in that cycle, the new word is accepted and its start bit begins on the next clock, with no extra idle bit.
    - Otherwise the FSM returns to IDLE.
  - tx_data changes while tx_ready = 0 are ignored.
- RX input: 2-flop synchroniser on rx, reset value 1. All RX logic uses the synchronised signal rxs.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1-to-0 transition of rxs starts the bit counter at 0 and enters START.
  - Sampling: in every bit, take samples at counter values H-1, H and H+1, where H = DIVIDER/2. The bit value is the majority of the 3 samples, decided at H+1.
  - START: if the voted start bit is 1, it is a false start; return to IDLE with no rx_valid.
  - DATA: shift in DATA_BITS voted bits, LSB first.
  - PARITY: if enabled, compare the voted parity bit with the computed parity and set the parity error accordingly.
  - STOP: only the first stop bit is checked. A voted 0 means framing error.
  - At the H+1 decision of the first stop bit, on the following clock: rx_valid = 1 for exactly one cycle, rx_data and the flags are updated, and the FSM returns to IDLE. It can detect a new start edge on the same cycle rx_valid pulses.
  - A framing error still delivers the data with rx_valid. If rxs stays low after the frame, there is no new start until rxs has been seen high.
- RX and TX are fully independent. Simultaneous TX acceptance and RX completion in the same cycle are both honoured.
- Latency:
  - tx falls 1 clock after acceptance.
  - rx_valid occurs 2 (sync) + 1 clocks after the stop-bit decision sample, i.e. about H+4 clocks into the stop bit as seen on the rx pin.

Test Plan:
1. CLK_FREQ = 1_000_000, BAUD_RATE = 100_000 (DIVIDER = 10), 8N1. Send 0xA5 → tx shows 0, 1,0,1,0,0,1,0,1, 1 at 10 clocks per bit; tx_ready is low for 99 clocks and high again on the 100th; loopback tx→rx gives rx_valid pulse with rx_data = 0xA5 and both flags 0.
2. Back-to-back: hold tx_valid with 0x00 then 0xFF → the second start bit follows the first stop bit with no idle gap; the receiver reports 0x00 then 0xFF, exactly 100 clocks apart.
3. DATA_BITS = 7, PARITY = 2, STOP_BITS = 2. Send 0x55 → frame is 0, 1010101, parity 0, 1, 1 (total 11 bits). A bench-injected frame with the parity bit flipped → rx_valid with rx_data = 0x55 and rx_parity_err = 1.
4. Framing error: drive 0x3C with the stop bit held low (8N1) → rx_valid, rx_data = 0x3C, rx_frame_err = 1; no new frame until rx is high, then a clean frame of 0x12 is received with flags 0.
5. Glitch robustness: a 3-clock low pulse on idle rx → no rx_valid. A single-clock inverted glitch at the mid-bit of data bit 3 of 0x81 → still received as 0x81.
6. Reset during TX data bit 4 and during RX data bit 2 → tx = 1 and tx_ready = 1 immediately; no rx_valid; after release, a fresh 0x5A transfers correctly.

Source files
------------

// File: rtl/uart_frame.sv
// Parametrised full-duplex UART: configurable width, parity and stop bits, valid/ready TX
// with back-to-back frames, RX with false-start rejection, 3-sample voting and error flags.
module uart_frame #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
    localparam int H       = DIVIDER / 2;
    localparam int CNT_W   = $clog2(DIVIDER);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       CNT_LAST  = cnt_t'(DIVIDER - 1);
    localparam cnt_t       CNT_PRE   = cnt_t'(DIVIDER - 2);
    localparam cnt_t       CNT_HM1   = cnt_t'(H - 1);
    localparam cnt_t       CNT_H     = cnt_t'(H);
    localparam cnt_t       CNT_HP1   = cnt_t'(H + 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    if (DIVIDER < 8) begin : g_bad_divider
        $error("uart_frame: CLK_FREQ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Parity bit that completes the word to odd (PARITY=1) or even (PARITY=2) ones count.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) return ~^d;
        return ^d;
    endfunction

    state_t                 tx_state;
    cnt_t                   tx_cnt;
    logic [3:0]             tx_idx;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
        end else if (tx_state == S_IDLE) begin
            if (tx_valid && tx_ready) begin
                tx_shift <= tx_data;
                tx_par   <= parity_bit(tx_data);
                tx       <= 1'b0;
                tx_ready <= 1'b0;
                tx_cnt   <= '0;
                tx_state <= S_START;
            end
        end else if (tx_cnt != CNT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
            // Open the handshake for the final clock of the last stop bit.
            if (tx_state == S_STOP && tx_idx == STOP_LAST && tx_cnt == CNT_PRE)
                tx_ready <= 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                S_START: begin
                    tx_state <= S_DATA;
                    tx_idx   <= '0;
                    tx       <= tx_shift[0];
                end
                S_DATA: begin
                    if (tx_idx == DATA_LAST) begin
                        tx_idx <= '0;
                        if (PARITY != 0) begin
                            tx_state <= S_PARITY;
                            tx       <= tx_par;
                        end else begin
                            tx_state <= S_STOP;
                            tx       <= 1'b1;
                        end
                    end else begin
                        tx_idx   <= tx_idx + 4'd1;
                        tx       <= tx_shift[1];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                S_PARITY: begin
                    tx_state <= S_STOP;
                    tx_idx   <= '0;
                    tx       <= 1'b1;
                end
                S_STOP: begin
                    if (tx_idx != STOP_LAST) begin
                        tx_idx <= tx_idx + 4'd1;
                    end else if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        tx_par   <= parity_bit(tx_data);
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_state <= S_START;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    state_t                 rx_state;
    cnt_t                   rx_cnt;
    logic [3:0]             rx_idx;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_s1, rxs, rxs_d;
    logic                   smp0, smp1;
    logic                   par_err;
    logic                   vote;

    assign vote = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1         <= 1'b1;
            rxs           <= 1'b1;
            rxs_d         <= 1'b1;
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            smp0          <= 1'b1;
            smp1          <= 1'b1;
            par_err       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rxs      <= rx_s1;
            rxs_d    <= rxs;
            rx_valid <= 1'b0;
            // A start needs a genuine high-to-low edge, so a line stuck low never retriggers.
            if (rx_state == S_IDLE) begin
                if (rxs_d && !rxs) begin
                    rx_state <= S_START;
                    rx_cnt   <= '0;
                end
            end else begin
                rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + 1'b1;
                if (rx_cnt == CNT_HM1) smp0 <= rxs;
                if (rx_cnt == CNT_H)   smp1 <= rxs;
                if (rx_cnt == CNT_HP1) begin
                    case (rx_state)
                        S_START: begin
                            if (vote) begin
                                rx_state <= S_IDLE;
                            end else begin
                                rx_state <= S_DATA;
                                rx_idx   <= '0;
                            end
                        end
                        S_DATA: begin
                            rx_shift <= {vote, rx_shift[DATA_BITS-1:1]};
                            if (rx_idx == DATA_LAST) begin
                                par_err  <= 1'b0;
                                rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                rx_idx <= rx_idx + 4'd1;
                            end
                        end
                        S_PARITY: begin
                            par_err  <= vote ^ parity_bit(rx_shift);
                            rx_state <= S_STOP;
                        end
                        S_STOP: begin
                            rx_valid      <= 1'b1;
                            rx_data       <= rx_shift;
                            rx_parity_err <= par_err;
                            rx_frame_err  <= ~vote;
                            rx_state      <= S_IDLE;
                        end
                        default: rx_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame.sv
// Bench for uart_frame: an 8N1 instance and a 7E2 instance, directed frames, RX scoreboard.
module tb_uart_frame;

    localparam int DIV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic [7:0] txd_a, rxd_a;
    logic       txv_a, txr_a, tx_a, rx_a, rxv_a, rxpe_a, rxfe_a, rx_drv_a, loop_a;
    logic [6:0] txd_b, rxd_b;
    logic       txv_b, txr_b, tx_b, rx_b, rxv_b, rxpe_b, rxfe_b, rx_drv_b, loop_b;

    assign rx_a = loop_a ? tx_a : rx_drv_a;
    assign rx_b = loop_b ? tx_b : rx_drv_b;

    uart_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(txr_a),
        .tx(tx_a), .rx(rx_a), .rx_data(rxd_a), .rx_valid(rxv_a),
        .rx_parity_err(rxpe_a), .rx_frame_err(rxfe_a));

    uart_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(txr_b),
        .tx(tx_b), .rx(rx_b), .rx_data(rxd_b), .rx_valid(rxv_b),
        .rx_parity_err(rxpe_b), .rx_frame_err(rxfe_b));

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   rva_t[$];
    int   n_rv_a = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic mon_a();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rxv_a === 1'b1) begin
                n_rv_a++;
                rva_t.push_back(cyc);
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_a_unexpected: actual rx_valid with data %0h required none", rxd_a);
                end else begin
                    e = qa.pop_front();
                    check("rx_a_data", 32'(rxd_a), 32'(e.data));
                    check("rx_a_parity_err", 32'(rxpe_a), 32'(e.perr));
                    check("rx_a_frame_err", 32'(rxfe_a), 32'(e.ferr));
                end
            end
        end
    endtask

    task automatic mon_b();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rxv_b === 1'b1) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_b_unexpected: actual rx_valid with data %0h required none", rxd_b);
                end else begin
                    e = qb.pop_front();
                    check("rx_b_data", 32'(rxd_b), 32'(e.data));
                    check("rx_b_parity_err", 32'(rxpe_b), 32'(e.perr));
                    check("rx_b_frame_err", 32'(rxfe_b), 32'(e.ferr));
                end
            end
        end
    endtask

    task automatic wait_drain(input int which);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) done = 1;
            else @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: actual %0d frames pending on dut %0d required 0",
                     (which == 0) ? qa.size() : qb.size(), which);
        end
    endtask

    // Drive a bit sequence (LSB = first bit on the line) onto one receiver's rx pin.
    task automatic drive(input int which, input logic [15:0] bits, input int n,
                         input int glitch_bit, input logic idle_lvl);
        logic v;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                v = (i == glitch_bit && c == 5) ? ~bits[i] : bits[i];
                if (which == 0) rx_drv_a = v;
                else rx_drv_b = v;
            end
        end
        @(negedge clk);
        if (which == 0) rx_drv_a = idle_lvl;
        else rx_drv_b = idle_lvl;
    endtask

    // Send one word on dut_a, check line bits at mid-bit and the tx_ready window.
    task automatic tx_frame_a(input logic [7:0] d, input logic [9:0] line);
        int lowcnt = 0;
        txd_a = d;
        txv_a = 1'b1;
        @(posedge clk);
        #1 txv_a = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (txr_a == 1'b0) lowcnt++;
            if (k % 10 == 5) check($sformatf("tx_a_bit%0d", k / 10), 32'(tx_a), 32'(line[k / 10]));
            if (k == 100) check("tx_a_ready_last_clock", 32'(txr_a), 32'd1);
        end
        check("tx_a_ready_low_clocks", 32'(lowcnt), 32'd99);
    endtask

    initial begin
        int t0, t1, n0, lowcnt;
        rst_n = 1'b0;
        txd_a = '0; txv_a = 1'b0; txd_b = '0; txv_b = 1'b0;
        rx_drv_a = 1'b1; rx_drv_b = 1'b1; loop_a = 1'b0; loop_b = 1'b0;
        fork
            mon_a();
            mon_b();
        join_none
        repeat (3) @(negedge clk);
        check("rst_tx_a", 32'(tx_a), 32'd1);
        check("rst_tx_ready_a", 32'(txr_a), 32'd1);
        check("rst_rx_valid_a", 32'(rxv_a), 32'd0);
        check("rst_rx_data_a", 32'(rxd_a), 32'd0);
        check("rst_rx_perr_a", 32'(rxpe_a), 32'd0);
        check("rst_rx_ferr_a", 32'(rxfe_a), 32'd0);
        check("rst_tx_b", 32'(tx_b), 32'd1);
        check("rst_tx_ready_b", 32'(txr_b), 32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 over loopback: line 0,1,0,1,0,0,1,0,1,1
        loop_a = 1'b1;
        qa.push_back(mk(9'h0A5, 1'b0, 1'b0));
        tx_frame_a(8'hA5, 10'b1_1010_0101_0);
        wait_drain(0);
        repeat (20) @(negedge clk);

        // back-to-back 0x00 then 0xFF with tx_valid held
        rva_t.delete();
        qa.push_back(mk(9'h000, 1'b0, 1'b0));
        qa.push_back(mk(9'h0FF, 1'b0, 1'b0));
        check("b2b_ready_idle", 32'(txr_a), 32'd1);
        txd_a = 8'h00;
        txv_a = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        txd_a = 8'hFF;
        for (int i = 0; i < 200 && txr_a !== 1'b1; i++) @(negedge clk);
        check("b2b_stop_high", 32'(tx_a), 32'd1);
        @(posedge clk);
        #1 t1 = cyc;
        txv_a = 1'b0;
        check("b2b_accept_spacing", 32'(t1 - t0), 32'd100);
        @(negedge clk);
        check("b2b_second_start", 32'(tx_a), 32'd0);
        wait_drain(0);
        check("b2b_rx_count", 32'(rva_t.size()), 32'd2);
        if (rva_t.size() == 2) check("b2b_rx_spacing", 32'(rva_t[1] - rva_t[0]), 32'd100);
        repeat (30) @(negedge clk);

        // 7E2: 0x55 -> 0, 1010101, parity 0, 1, 1
        loop_b = 1'b1;
        qb.push_back(mk(9'h055, 1'b0, 1'b0));
        lowcnt = 0;
        txd_b = 7'h55;
        txv_b = 1'b1;
        @(posedge clk);
        #1 txv_b = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            logic [10:0] line_b;
            line_b = 11'h6AA;
            @(negedge clk);
            if (txr_b == 1'b0) lowcnt++;
            if (k % 10 == 5) check($sformatf("tx_b_bit%0d", k / 10), 32'(tx_b), 32'(line_b[k / 10]));
        end
        check("tx_b_ready_low_clocks", 32'(lowcnt), 32'd109);
        wait_drain(1);
        loop_b = 1'b0;
        repeat (20) @(negedge clk);
        qb.push_back(mk(9'h055, 1'b1, 1'b0));
        drive(1, 16'h07AA, 11, -1, 1'b1);
        wait_drain(1);
        repeat (20) @(negedge clk);

        // framing error on 0x3C, line stays low, then clean 0x12
        loop_a = 1'b0;
        n0 = n_rv_a;
        qa.push_back(mk(9'h03C, 1'b0, 1'b1));
        drive(0, 16'h0078, 10, -1, 1'b0);
        wait_drain(0);
        repeat (40) @(negedge clk);
        check("ferr_no_restart", 32'(n_rv_a - n0), 32'd1);
        rx_drv_a = 1'b1;
        repeat (20) @(negedge clk);
        qa.push_back(mk(9'h012, 1'b0, 1'b0));
        drive(0, 16'h0224, 10, -1, 1'b1);
        wait_drain(0);
        repeat (20) @(negedge clk);

        // glitches: 3-clock low pulse, then 0x81 with data bit 3 inverted for one clock
        n0 = n_rv_a;
        rx_drv_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv_a = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start_rejected", 32'(n_rv_a - n0), 32'd0);
        qa.push_back(mk(9'h081, 1'b0, 1'b0));
        drive(0, 16'h0302, 10, 4, 1'b1);
        wait_drain(0);
        repeat (20) @(negedge clk);

        // reset during TX data bit 4 of 0xC3
        txd_a = 8'hC3;
        txv_a = 1'b1;
        @(posedge clk);
        #1 txv_a = 1'b0;
        repeat (55) @(negedge clk);
        check("tx_mid_bit4", 32'(tx_a), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx_a), 32'd1);
        check("rst_mid_tx_ready", 32'(txr_a), 32'd1);
        check("rst_mid_rx_data", 32'(rxd_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // reset during RX data bit 2 of an all-zero frame
        n0 = n_rv_a;
        rx_drv_a = 1'b0;
        repeat (35) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rx_valid", 32'(rxv_a), 32'd0);
        rx_drv_a = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("rst_mid_rx_no_frame", 32'(n_rv_a - n0), 32'd0);

        // fresh 0x5A after reset: line 0,0,1,0,1,1,0,1,0,1
        loop_a = 1'b1;
        qa.push_back(mk(9'h05A, 1'b0, 1'b0));
        tx_frame_a(8'h5A, 10'b1_0101_1010_0);
        wait_drain(0);
        repeat (20) @(negedge clk);

        check("final_queue_a", 32'(qa.size()), 32'd0);
        check("final_queue_b", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
